// File: rtl/sme_pkg.sv
// Shared types, defaults and helpers for the SME masking path.
package sme_pkg;

    localparam int unsigned SME_XLEN = 32;
    localparam int unsigned SME_SMAX = 4;

    typedef enum logic [1:0] {
        SME_UNMASK_IDLE,
        SME_UNMASK_FOLD,
        SME_UNMASK_HOLD
    } sme_unmask_state_t;

    // Requested share count -> count actually used: 0 means 1, anything above smax means smax.
    function automatic logic [3:0] sme_clamp_d(input logic [3:0] d, input int unsigned smax);
        if (d == 4'd0) begin
            return 4'd1;
        end else if (32'(d) > smax) begin
            return 4'(smax);
        end else begin
            return d;
        end
    endfunction

endpackage

// File: rtl/sme_unmask_seq.sv
// Sequential share recombiner: folds up to SMAX masked shares into a plaintext
// result, one share per cycle (XOR for boolean masking, ADD mod 2^XLEN for arithmetic).
// Ports:
//   g_clk, g_resetn   clock, synchronous active-low reset
//   flush             abort the current op and clear all state
//   smectl_t          masking type (0 XOR, 1 ADD), sampled on accept
//   smectl_d          requested share count, clamped and sampled on accept
//   in_valid/in_ready/in_shares    input handshake and share vector (share 0 in the low word)
//   out_valid/out_ready/out_data   result handshake; out_data is 0 while out_valid is low
//   busy              high whenever the FSM is not idle
module sme_unmask_seq
    import sme_pkg::*;
#(
    parameter int unsigned XLEN = SME_XLEN,
    parameter int unsigned SMAX = SME_SMAX
) (
    input  logic                       g_clk,
    input  logic                       g_resetn,
    input  logic                       flush,
    input  logic                       smectl_t,
    input  logic [3:0]                 smectl_d,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SMAX-1:0][XLEN-1:0]  in_shares,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_data,
    output logic                       busy
);

    localparam int unsigned IDXW  = $clog2(SMAX) + 1;
    localparam int unsigned SIDXW = $clog2(SMAX);

    sme_unmask_state_t r_state;
    sme_unmask_state_t w_state_nxt;

    logic [XLEN-1:0] r_shares [SMAX];
    logic [XLEN-1:0] r_acc;
    logic [IDXW-1:0] r_idx;
    logic [IDXW-1:0] r_nd;
    logic            r_t;

    logic            w_accept;
    logic            w_last;
    logic [IDXW-1:0] w_nd_in;
    logic [XLEN-1:0] w_share;
    logic [XLEN-1:0] w_fold;

    assign in_ready  = (r_state == SME_UNMASK_IDLE) && !flush;
    assign w_accept  = in_valid && in_ready;
    assign w_nd_in   = IDXW'(sme_clamp_d(smectl_d, SMAX));
    assign w_last    = (r_idx == (r_nd - IDXW'(1)));

    // Single fold datapath; idx never exceeds SMAX-1 while folding, so the low bits address the share.
    assign w_share   = r_shares[r_idx[SIDXW-1:0]];
    assign w_fold    = r_t ? (r_acc + w_share) : (r_acc ^ w_share);

    assign out_valid = (r_state == SME_UNMASK_HOLD);
    assign out_data  = out_valid ? r_acc : '0;
    assign busy      = (r_state != SME_UNMASK_IDLE);

    // State register.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_state <= SME_UNMASK_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SME_UNMASK_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (w_nd_in == IDXW'(1)) ? SME_UNMASK_HOLD : SME_UNMASK_FOLD;
                end
            end
            SME_UNMASK_FOLD: begin
                if (w_last) begin
                    w_state_nxt = SME_UNMASK_HOLD;
                end
            end
            SME_UNMASK_HOLD: begin
                if (out_ready) begin
                    w_state_nxt = SME_UNMASK_IDLE;
                end
            end
            default: w_state_nxt = SME_UNMASK_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = SME_UNMASK_IDLE;
        end
    end

    // Datapath registers; plaintext is wiped as soon as it is consumed or aborted.
    always_ff @(posedge g_clk) begin
        if (!g_resetn || flush) begin
            r_acc <= '0;
            r_idx <= '0;
            r_nd  <= '0;
            r_t   <= 1'b0;
            for (int i = 0; i < int'(SMAX); i++) begin
                r_shares[i] <= '0;
            end
        end else begin
            case (r_state)
                SME_UNMASK_IDLE: begin
                    if (w_accept) begin
                        r_acc <= in_shares[0];
                        r_idx <= IDXW'(1);
                        r_nd  <= w_nd_in;
                        r_t   <= smectl_t;
                        for (int i = 0; i < int'(SMAX); i++) begin
                            r_shares[i] <= in_shares[i];
                        end
                    end
                end
                SME_UNMASK_FOLD: begin
                    r_acc <= w_fold;
                    r_idx <= r_idx + IDXW'(1);
                end
                SME_UNMASK_HOLD: begin
                    if (out_ready) begin
                        r_acc <= '0;
                        r_idx <= '0;
                        for (int i = 0; i < int'(SMAX); i++) begin
                            r_shares[i] <= '0;
                        end
                    end
                end
                default: begin
                    r_acc <= '0;
                    r_idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sme_unmask_seq.sv
// Scoreboard bench for sme_unmask_seq: the driver pushes expected results, a monitor
// pops and compares data and accept-to-valid latency on every output handshake.
module tb_sme_unmask_seq;

    logic              g_clk;
    logic              g_resetn;
    logic              flush;
    logic              smectl_t;
    logic [3:0]        smectl_d;
    logic              in_valid;
    logic              in_ready;
    logic [3:0][31:0]  in_shares;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic              busy;

    sme_unmask_seq #(.XLEN(32), .SMAX(4)) dut (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .flush     (flush),
        .smectl_t  (smectl_t),
        .smectl_d  (smectl_d),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_shares (in_shares),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    typedef struct {
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   total    = 0;
    int   bad      = 0;
    int   pushed   = 0;
    int   popped   = 0;
    int   cyc      = 0;
    int   acc_edge = 0;
    int   cur_lat  = 0;
    logic prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge g_clk) cyc <= cyc + 1;

    // Monitor: latency tracking and scoreboard comparison on the inactive edge.
    always @(negedge g_clk) begin
        if (g_resetn) begin
            if (in_valid && in_ready) acc_edge = cyc + 1;
            if (out_valid && !prev_valid) cur_lat = cyc - acc_edge + 1;
            if (out_valid && out_ready) begin
                exp_t e;
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got %h expected no result", out_data);
                end else begin
                    e = sb_q.pop_front();
                    popped++;
                    check("result_data", out_data, e.data);
                    check("result_latency", 32'(cur_lat), 32'(e.lat));
                end
            end
        end
        prev_valid = out_valid && g_resetn;
    end

    function automatic logic [3:0][31:0] pack4(input logic [31:0] s0, input logic [31:0] s1,
                                               input logic [31:0] s2, input logic [31:0] s3);
        logic [3:0][31:0] v;
        v[0] = s0; v[1] = s1; v[2] = s2; v[3] = s3;
        return v;
    endfunction

    // Issue one op; push the expected result only if it is expected to be delivered.
    task automatic issue(input logic t, input logic [3:0] d, input logic [3:0][31:0] sh,
                         input logic do_push, input logic [31:0] exp_data, input int exp_lat);
        int n;
        exp_t e;
        n = 0;
        @(posedge g_clk); #1;
        while (!in_ready && n < 50) begin
            @(posedge g_clk); #1;
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: got in_ready=%b expected 1", in_ready);
        end
        if (do_push) begin
            e.data = exp_data;
            e.lat  = exp_lat;
            sb_q.push_back(e);
            pushed++;
        end
        smectl_t  = t;
        smectl_d  = d;
        in_shares = sh;
        in_valid  = 1'b1;
        @(posedge g_clk); #1;
        in_valid  = 1'b0;
        smectl_t  = ~t;
        smectl_d  = 4'd1;
        in_shares = pack4(32'hDEAD0000, 32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || out_valid) && n < 100) begin
            @(negedge g_clk);
            n++;
        end
        if (busy || out_valid) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got busy=%b expected 0", busy);
        end
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        @(negedge g_clk);
        while (!out_valid && n < 100) begin
            @(negedge g_clk);
            n++;
        end
        if (!out_valid) begin
            total++;
            bad++;
            $display("FAIL valid_timeout: got out_valid=%b expected 1", out_valid);
        end
    endtask

    initial begin
        g_resetn  = 1'b0;
        flush     = 1'b0;
        smectl_t  = 1'b0;
        smectl_d  = 4'd0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_shares = '0;
        repeat (3) @(posedge g_clk);
        #1 g_resetn = 1'b1;
        @(negedge g_clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data",  out_data,       32'd0);
        check("reset_busy",      32'(busy),      32'd0);
        check("reset_in_ready",  32'(in_ready),  32'd1);

        // Boolean, 2 shares; shares 2,3 are garbage and must be ignored.
        issue(1'b0, 4'd2, pack4(32'hA5A5A5A5, 32'hFFFF0000, 32'h11111111, 32'h22222222), 1'b1, 32'h5A5AA5A5, 2);
        wait_idle();
        // Arithmetic, 3 shares with carry wrap.
        issue(1'b1, 4'd3, pack4(32'hFFFFFFFF, 32'h00000002, 32'h00000010, 32'h33333333), 1'b1, 32'h00000011, 3);
        wait_idle();
        // d=0 clamps to 1: share 0 passes through.
        issue(1'b1, 4'd0, pack4(32'h12345678, 32'h44444444, 32'h55555555, 32'h66666666), 1'b1, 32'h12345678, 1);
        wait_idle();
        // d=9 clamps to 4, arithmetic: 1+2+3+4.
        issue(1'b1, 4'd9, pack4(32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004), 1'b1, 32'h0000000A, 4);
        wait_idle();
        // d=15 clamps to 4, boolean.
        issue(1'b0, 4'd15, pack4(32'h00000001, 32'h00000002, 32'h00000004, 32'h80000008), 1'b1, 32'h8000000F, 4);
        wait_idle();

        // Backpressure: result held, input blocked.
        out_ready = 1'b0;
        issue(1'b0, 4'd1, pack4(32'hCAFEBABE, 32'h0, 32'h0, 32'h0), 1'b1, 32'hCAFEBABE, 1);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(posedge g_clk); #1;
            in_valid  = (i == 2);
            in_shares = pack4(32'hBADBAD00, 32'h1, 32'h2, 32'h3);
            @(negedge g_clk);
            check("hold_data",     out_data,       32'hCAFEBABE);
            check("hold_in_ready", 32'(in_ready),  32'd0);
            check("hold_valid",    32'(out_valid), 32'd1);
        end
        @(posedge g_clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge g_clk);
        @(negedge g_clk);
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_out_data", out_data,      32'd0);
        check("release_busy",     32'(busy),     32'd0);

        // Flush in the second FOLD cycle of a 4-share op.
        issue(1'b0, 4'd4, pack4(32'h1, 32'h2, 32'h4, 32'h8), 1'b0, 32'h0, 0);
        @(posedge g_clk); #1;
        flush = 1'b1;
        @(negedge g_clk);
        check("flush_busy_before", 32'(busy),     32'd1);
        check("flush_in_ready",    32'(in_ready), 32'd0);
        @(posedge g_clk); #1;
        flush = 1'b0;
        @(negedge g_clk);
        check("flush_busy_after",  32'(busy),      32'd0);
        check("flush_out_valid",   32'(out_valid), 32'd0);
        check("flush_out_data",    out_data,       32'd0);
        repeat (5) @(negedge g_clk);
        check("flush_no_result",   32'(out_valid), 32'd0);

        // Flush together with in_valid in IDLE: nothing accepted.
        @(posedge g_clk); #1;
        flush     = 1'b1;
        in_valid  = 1'b1;
        smectl_d  = 4'd1;
        in_shares = pack4(32'h77777777, 32'h0, 32'h0, 32'h0);
        @(negedge g_clk);
        check("flush_accept_in_ready", 32'(in_ready), 32'd0);
        @(posedge g_clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge g_clk);
        check("flush_accept_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge g_clk);

        // Reset during HOLD drops the result; the next op must be clean.
        out_ready = 1'b0;
        issue(1'b0, 4'd2, pack4(32'h0F0F0F0F, 32'hF0F0F0F0, 32'h0, 32'h0), 1'b0, 32'h0, 0);
        wait_valid();
        check("pre_reset_data", out_data, 32'hFFFFFFFF);
        @(posedge g_clk); #1;
        g_resetn = 1'b0;
        repeat (2) @(posedge g_clk);
        #1 g_resetn = 1'b1;
        @(negedge g_clk);
        check("rst_hold_out_valid", 32'(out_valid), 32'd0);
        check("rst_hold_out_data",  out_data,       32'd0);
        check("rst_hold_in_ready",  32'(in_ready),  32'd1);
        check("rst_hold_busy",      32'(busy),      32'd0);
        out_ready = 1'b1;
        issue(1'b1, 4'd2, pack4(32'h80000000, 32'h80000001, 32'h0, 32'h0), 1'b1, 32'h00000001, 2);
        wait_idle();
        repeat (3) @(negedge g_clk);

        check("sb_empty",      32'(sb_q.size()), 32'd0);
        check("results_count", 32'(popped),      32'(pushed));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
